// File: rtl/bsg_xor_pkg.sv
// Shared types and helpers for the streaming XOR accumulator.
package bsg_xor_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } frame_state_e;

  // Width needed to hold the values 0..max_beats.
  function automatic int calc_cw(input int max_beats);
    int w;
    w = 1;
    while ((1 << w) <= max_beats) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bsg_xor_accum_if.sv
// Beat input stream plus valid/yumi result port of bsg_xor_accum.
interface bsg_xor_accum_if
  import bsg_xor_pkg::*;
#(
  parameter int width_p     = 16,
  parameter int max_beats_p = 256
);
  localparam int cw = calc_cw(max_beats_p);

  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] a_i;
  logic [width_p-1:0] b_i;
  logic               last_i;
  logic               bypass_i;
  logic               v_o;
  logic               yumi_i;
  logic [width_p-1:0] data_o;
  logic [cw-1:0]      count_o;
  logic               overflow_o;

  modport slave (
    input  v_i, a_i, b_i, last_i, bypass_i, yumi_i,
    output ready_o, v_o, data_o, count_o, overflow_o
  );

  modport master (
    output v_i, a_i, b_i, last_i, bypass_i, yumi_i,
    input  ready_o, v_o, data_o, count_o, overflow_o
  );

endinterface

// File: rtl/bsg_xor_accum_chk.sv
// Simulation-only protocol checker for the bsg_xor_accum result port.
module bsg_xor_accum_chk (
  input logic clk_i,
  input logic reset_i,
  input logic v_o,
  input logic yumi_i
);

  yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o
  ) else $error("bsg_xor_accum: yumi_i asserted while v_o=0");

endmodule

// File: rtl/bsg_xor_out_buf.sv
// One-entry valid/yumi result register; ready_o lets a new result replace
// the held one in the cycle the consumer takes it.
module bsg_xor_out_buf #(
  parameter int width_p = 16,
  parameter int cw_p    = 9
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] data_i,
  input  logic [cw_p-1:0]    count_i,
  input  logic               overflow_i,
  input  logic               yumi_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic [cw_p-1:0]    count_o,
  output logic               overflow_o
);

  logic               v_q, v_d;
  logic [width_p-1:0] data_q, data_d;
  logic [cw_p-1:0]    count_q, count_d;
  logic               ovf_q, ovf_d;

  assign ready_o    = ~v_q | yumi_i;
  assign v_o        = v_q;
  assign data_o     = data_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

  always_comb begin
    v_d     = v_q;
    data_d  = data_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (load_i) begin
      v_d     = 1'b1;
      data_d  = data_i;
      count_d = count_i;
      ovf_d   = overflow_i;
    end else if (yumi_i) begin
      v_d = 1'b0;
    end else begin
      v_d = v_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_q     <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      v_q     <= v_d;
      data_q  <= data_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: rtl/bsg_xor_accum.sv
// Streaming XOR fold: folds a_i^b_i over every beat of a frame and hands the
// result plus a saturating beat count to a one-entry valid/yumi buffer.
module bsg_xor_accum
  import bsg_xor_pkg::*;
#(
  parameter int                 width_p     = 16,
  parameter int                 max_beats_p = 256,
  parameter logic [width_p-1:0] seed_p      = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  bsg_xor_accum_if.slave  io
);

  localparam int            cw      = calc_cw(max_beats_p);
  localparam logic [cw-1:0] max_cnt = cw'(max_beats_p);

  frame_state_e       state_q, state_d;
  logic [width_p-1:0] acc_q, acc_d;
  logic [cw-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               byp_q, byp_d;

  logic               accept;
  logic               eff_bypass;
  logic               is_last;
  logic [width_p-1:0] nacc;
  logic [cw-1:0]      ncnt;
  logic               novf;
  logic               load;

  assign accept     = io.v_i & io.ready_o;
  assign eff_bypass = (state_q == ACCUM) ? byp_q : io.bypass_i;
  assign is_last    = io.last_i | eff_bypass;
  assign nacc       = acc_q ^ io.a_i ^ io.b_i;
  assign ncnt       = (cnt_q == max_cnt) ? cnt_q : cnt_q + cw'(1);
  assign novf       = ovf_q | (cnt_q == max_cnt);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    byp_d   = byp_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_last) begin
            load  = 1'b1;
            acc_d = seed_p;
            cnt_d = '0;
            ovf_d = 1'b0;
          end else begin
            state_d = ACCUM;
            byp_d   = io.bypass_i;
            acc_d   = nacc;
            cnt_d   = ncnt;
            ovf_d   = novf;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (is_last) begin
            // Frame closes: result goes out, accumulator restarts from the seed.
            state_d = IDLE;
            load    = 1'b1;
            acc_d   = seed_p;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            acc_d = nacc;
            cnt_d = ncnt;
            ovf_d = novf;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = seed_p;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        byp_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      acc_q   <= seed_p;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      byp_q   <= byp_d;
    end
  end

  bsg_xor_out_buf #(
    .width_p (width_p),
    .cw_p    (cw)
  ) u_out_buf (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (load),
    .data_i     (nacc),
    .count_i    (ncnt),
    .overflow_i (novf),
    .yumi_i     (io.yumi_i),
    .ready_o    (io.ready_o),
    .v_o        (io.v_o),
    .data_o     (io.data_o),
    .count_o    (io.count_o),
    .overflow_o (io.overflow_o)
  );

endmodule

// File: tb/tb_bsg_xor_accum.sv
// Directed self-checking bench for bsg_xor_accum (max_beats_p=4, seed 0).
module tb_bsg_xor_accum;

  logic clk_i;
  logic reset_i;
  int   n_tests;
  int   n_fail;

  bsg_xor_accum_if #(.width_p(16), .max_beats_p(4)) io ();

  bsg_xor_accum #(
    .width_p     (16),
    .max_beats_p (4),
    .seed_p      (16'h0000)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .io      (io)
  );

  bsg_xor_accum_chk u_chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_o     (io.v_o),
    .yumi_i  (io.yumi_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last);
    io.v_i    = 1'b1;
    io.a_i    = a;
    io.b_i    = b;
    io.last_i = last;
    tick();
    io.v_i    = 1'b0;
    io.last_i = 1'b0;
  endtask

  task automatic consume();
    io.yumi_i = 1'b1;
    tick();
    io.yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++; if (io.v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v: got %b want 0", io.v_o); end
    n_tests++; if (io.data_o !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", io.data_o); end
    n_tests++; if (io.count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", io.count_o); end
    n_tests++; if (io.overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", io.overflow_o); end
    n_tests++; if (io.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", io.ready_o); end
  endtask

  task automatic test_single();
    beat(16'h00FF, 16'h0F0F, 1'b1);
    n_tests++; if (io.v_o !== 1'b1) begin n_fail++; $display("FAIL single_v: got %b want 1", io.v_o); end
    n_tests++; if (io.data_o !== 16'h0FF0) begin n_fail++; $display("FAIL single_data: got %h want 0ff0", io.data_o); end
    n_tests++; if (io.count_o !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", io.count_o); end
    n_tests++; if (io.overflow_o !== 1'b0) begin n_fail++; $display("FAIL single_ovf: got %b want 0", io.overflow_o); end
    consume();
    n_tests++; if (io.v_o !== 1'b0) begin n_fail++; $display("FAIL single_v_after_yumi: got %b want 0", io.v_o); end
  endtask

  task automatic test_three_beat();
    beat(16'h1234, 16'h0000, 1'b0);
    beat(16'h00FF, 16'hFF00, 1'b0);
    n_tests++; if (io.v_o !== 1'b0) begin n_fail++; $display("FAIL three_early_v: got %b want 0", io.v_o); end
    beat(16'hAAAA, 16'h5555, 1'b1);
    n_tests++; if (io.v_o !== 1'b1) begin n_fail++; $display("FAIL three_v: got %b want 1", io.v_o); end
    n_tests++; if (io.data_o !== 16'h1234) begin n_fail++; $display("FAIL three_data: got %h want 1234", io.data_o); end
    n_tests++; if (io.count_o !== 3'd3) begin n_fail++; $display("FAIL three_count: got %0d want 3", io.count_o); end
    consume();
  endtask

  task automatic test_back_to_back();
    beat(16'h0101, 16'h0010, 1'b1);
    // A non-last beat waits while the result is held.
    io.v_i    = 1'b1;
    io.a_i    = 16'h5555;
    io.b_i    = 16'h0000;
    io.last_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (io.ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, io.ready_o); end
      n_tests++; if (io.data_o !== 16'h0111 || io.count_o !== 3'd1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %h/%0d want 0111/1", i, io.data_o, io.count_o);
      end
      tick();
    end
    io.a_i    = 16'hFFFF;
    io.b_i    = 16'h0001;
    io.last_i = 1'b1;
    io.yumi_i = 1'b1;
    #1;
    n_tests++; if (io.ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", io.ready_o); end
    tick();
    io.v_i    = 1'b0;
    io.last_i = 1'b0;
    io.yumi_i = 1'b0;
    n_tests++; if (io.v_o !== 1'b1) begin n_fail++; $display("FAIL b2b_v: got %b want 1", io.v_o); end
    n_tests++; if (io.data_o !== 16'hFFFE || io.count_o !== 3'd1) begin
      n_fail++; $display("FAIL b2b_data: got %h/%0d want fffe/1", io.data_o, io.count_o);
    end
    consume();
    n_tests++; if (io.v_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", io.v_o); end
  endtask

  task automatic test_bypass();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [15:0] vx [4];
    va[0] = 16'h1111; vb[0] = 16'h2222; vx[0] = 16'h3333;
    va[1] = 16'hF0F0; vb[1] = 16'h0F00; vx[1] = 16'hFFF0;
    va[2] = 16'hABCD; vb[2] = 16'h0000; vx[2] = 16'hABCD;
    va[3] = 16'h8001; vb[3] = 16'h8001; vx[3] = 16'h0000;
    io.bypass_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      io.yumi_i = (i != 0);
      beat(va[i], vb[i], 1'b0);
      n_tests++; if (io.v_o !== 1'b1 || io.data_o !== vx[i] || io.count_o !== 3'd1 || io.overflow_o !== 1'b0) begin
        n_fail++; $display("FAIL bypass[%0d]: got v=%b %h/%0d/%b want v=1 %h/1/0", i, io.v_o, io.data_o, io.count_o, io.overflow_o, vx[i]);
      end
    end
    io.bypass_i = 1'b0;
    consume();
    // bypass_i rising mid-frame must not split the frame.
    beat(16'h0001, 16'h0000, 1'b0);
    io.bypass_i = 1'b1;
    beat(16'h0002, 16'h0000, 1'b0);
    n_tests++; if (io.v_o !== 1'b0) begin n_fail++; $display("FAIL bypass_mid_v: got %b want 0", io.v_o); end
    beat(16'h0004, 16'h0000, 1'b1);
    io.bypass_i = 1'b0;
    n_tests++; if (io.data_o !== 16'h0007 || io.count_o !== 3'd3) begin
      n_fail++; $display("FAIL bypass_mid_data: got %h/%0d want 0007/3", io.data_o, io.count_o);
    end
    consume();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) beat(16'h0001, 16'h0000, (i == 5));
    n_tests++; if (io.data_o !== 16'h0000 || io.count_o !== 3'd4 || io.overflow_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf6: got %h/%0d/%b want 0000/4/1", io.data_o, io.count_o, io.overflow_o);
    end
    consume();
    beat(16'h0001, 16'h0000, 1'b0);
    beat(16'h0002, 16'h0000, 1'b0);
    beat(16'h0004, 16'h0000, 1'b0);
    beat(16'h0008, 16'h0000, 1'b1);
    n_tests++; if (io.data_o !== 16'h000F || io.count_o !== 3'd4 || io.overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_exact4: got %h/%0d/%b want 000f/4/0", io.data_o, io.count_o, io.overflow_o);
    end
    consume();
  endtask

  task automatic test_async_reset();
    beat(16'h00F0, 16'h0000, 1'b0);
    beat(16'h0F00, 16'h0000, 1'b0);
    #2;
    reset_i = 1'b1;
    #1;
    n_tests++; if (io.data_o !== 16'h0000 || io.count_o !== 3'd0 || io.v_o !== 1'b0) begin
      n_fail++; $display("FAIL async_clear: got v=%b %h/%0d want v=0 0000/0", io.v_o, io.data_o, io.count_o);
    end
    @(posedge clk_i);
    #3;
    reset_i = 1'b0;
    tick();
    beat(16'h0003, 16'h0001, 1'b1);
    n_tests++; if (io.v_o !== 1'b1 || io.data_o !== 16'h0002 || io.count_o !== 3'd1) begin
      n_fail++; $display("FAIL post_reset: got v=%b %h/%0d want v=1 0002/1", io.v_o, io.data_o, io.count_o);
    end
    consume();
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset_i     = 1'b1;
    io.v_i      = 1'b0;
    io.a_i      = 16'h0000;
    io.b_i      = 16'h0000;
    io.last_i   = 1'b0;
    io.bypass_i = 1'b0;
    io.yumi_i   = 1'b0;
    tick();
    tick();
    test_reset();
    #3;
    reset_i = 1'b0;
    tick();
    test_single();
    test_three_beat();
    test_back_to_back();
    test_bypass();
    test_overflow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
